// File: rtl/mem_addr_unit_pkg.sv
// Shared definitions for the memory address/data register stage.
//   - address select codes produced by the select logic
//   - transaction FSM state type (2-bit encoding)
//   - default address/data widths used by every core
package mem_addr_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned DATA_W_DEFAULT = 16;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ALT  = 2'b01;
  localparam logic [1:0] SEL_BUS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_addr_unit_ar_register.sv
// Memory address register (AR): load from bus, load from alternate path,
// increment (wrapping modulo 2^ADDR_W) or hold.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (AR cleared)
//   en           updates allowed (only while the transaction FSM is idle)
//   sel          select code: bit1 = bus, else bit0 = alt
//   bus_in       bus address
//   alt_in       alternate mux path address
//   inc          increment when no load is selected
//   ar           current AR value
module mem_addr_unit_ar_register
  import mem_addr_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] alt_in,
  input  logic              inc,
  output logic [ADDR_W-1:0] ar
);

  // Decode by bit so that 2'b11 resolves to the bus source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar <= '0;
    end else if (en) begin
      if (sel[SEL_BUS == 2'b10 ? 1 : 0]) begin
        ar <= bus_in;
      end else if (sel[SEL_ALT == 2'b01 ? 0 : 1]) begin
        ar <= alt_in;
      end else if (inc) begin
        ar <= ar + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Address/data register stage between the select logic and the core RAM.
// Holds AR, runs single read/write transactions to a synchronous RAM and
// captures read data into DR.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sel, bus_in, alt_in AR load select and sources
//   inc                 AR increment when no load is selected
//   rd_req, wr_req      transaction requests (write wins)
//   wr_data             write data, sampled with wr_req
//   mem_addr            RAM address (= AR)
//   mem_wen, mem_wdata  RAM write enable / data
//   mem_rdata           RAM read data (RD_LAT cycles after address)
//   ar_out, dr_out      current AR / DR
//   busy                transaction in flight (RD or WR)
//   done                one-cycle completion pulse
module mem_addr_unit
  import mem_addr_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] alt_in,
  input  logic              inc,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ar_out,
  output logic [DATA_W-1:0] dr_out,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ar;

  mem_addr_unit_ar_register #(
    .ADDR_W (ADDR_W)
  ) u_ar (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == ST_IDLE),
    .sel    (sel),
    .bus_in (bus_in),
    .alt_in (alt_in),
    .inc    (inc),
    .ar     (ar)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dr    <= '0;
      wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_req) begin
            wdata <= wr_data;
            state <= ST_WR;
          end else if (rd_req) begin
            cnt   <= '0;
            state <= ST_RD;
          end
        end
        ST_RD: begin
          cnt <= cnt + 2'd1;
          if (cnt == CNT_LAST) begin
            dr    <= mem_rdata;
            state <= ST_DONE;
          end
        end
        ST_WR:   state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = ar;
  assign ar_out    = ar;
  assign dr_out    = dr;
  assign mem_wdata = wdata;
  assign mem_wen   = (state == ST_WR);
  assign busy      = (state == ST_RD) || (state == ST_WR);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_mem_addr_unit.sv
// Bench for mem_addr_unit: two instances (RD_LAT=1 and RD_LAT=3) driven by
// the same stimulus, checked by a directed vector table, hand-written
// multi-cycle sequences and a transaction-level reference model.
module tb_mem_addr_unit;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    sel;
  logic [AW-1:0] bus_in, alt_in;
  logic          inc, rd_req, wr_req;
  logic [DW-1:0] wr_data;

  logic [AW-1:0] mem_addr_a, ar_a, mem_addr_b, ar_b;
  logic [DW-1:0] mem_wdata_a, mem_rdata_a, dr_a, mem_wdata_b, mem_rdata_b, dr_b;
  logic          mem_wen_a, busy_a, done_a, mem_wen_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  // RAM contents as a pure function of the address.
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Address is stable for the whole transaction, so a combinational read
  // satisfies any RD_LAT.
  assign mem_rdata_a = ram_f(mem_addr_a);
  assign mem_rdata_b = ram_f(mem_addr_b);

  mem_addr_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel), .bus_in(bus_in), .alt_in(alt_in),
    .inc(inc), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .mem_addr(mem_addr_a), .mem_wen(mem_wen_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .ar_out(ar_a), .dr_out(dr_a),
    .busy(busy_a), .done(done_a));

  mem_addr_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel), .bus_in(bus_in), .alt_in(alt_in),
    .inc(inc), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .mem_addr(mem_addr_b), .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .ar_out(ar_b), .dr_out(dr_b),
    .busy(busy_b), .done(done_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: cycles left in the current access,
  // its kind, and a pending completion flag.
  logic [AW-1:0] m_ar[2];
  logic [DW-1:0] m_dr[2], m_wd[2];
  int            m_left[2];
  bit            m_is_wr[2], m_done[2];
  bit            model_on = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      if (!rst_n) begin
        m_ar[i] = '0; m_dr[i] = '0; m_wd[i] = '0;
        m_left[i] = 0; m_is_wr[i] = 1'b0; m_done[i] = 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (!m_is_wr[i]) m_dr[i] = ram_f(m_ar[i]);
          m_done[i] = 1'b1;
        end
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else begin
        if (sel[1])      m_ar[i] = bus_in;
        else if (sel[0]) m_ar[i] = alt_in;
        else if (inc)    m_ar[i] = m_ar[i] + 16'd1;
        if (wr_req) begin
          m_wd[i] = wr_data; m_is_wr[i] = 1'b1; m_left[i] = 1;
        end else if (rd_req) begin
          m_is_wr[i] = 1'b0; m_left[i] = lat;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("a.ar",    ar_a,        m_ar[0]);
      chk("a.addr",  mem_addr_a,  m_ar[0]);
      chk("a.dr",    dr_a,        m_dr[0]);
      chk("a.wdata", mem_wdata_a, m_wd[0]);
      chk("a.busy",  busy_a,      m_left[0] > 0);
      chk("a.done",  done_a,      m_done[0]);
      chk("a.wen",   mem_wen_a,   m_left[0] > 0 && m_is_wr[0]);
      chk("b.ar",    ar_b,        m_ar[1]);
      chk("b.addr",  mem_addr_b,  m_ar[1]);
      chk("b.dr",    dr_b,        m_dr[1]);
      chk("b.wdata", mem_wdata_b, m_wd[1]);
      chk("b.busy",  busy_b,      m_left[1] > 0);
      chk("b.done",  done_b,      m_done[1]);
      chk("b.wen",   mem_wen_b,   m_left[1] > 0 && m_is_wr[1]);
    end
  end

  typedef struct {
    logic          rst_n;
    logic [1:0]    sel;
    logic [AW-1:0] bus, alt;
    logic          inc, rd, wr;
    logic [DW-1:0] wd;
    logic [AW-1:0] e_ar;
    logic [DW-1:0] e_dr, e_wd;
    logic          e_busy, e_done, e_wen;
  } vec_t;

  vec_t tbl[16];

  task automatic drive(input logic r, input logic [1:0] s, input logic [AW-1:0] b,
                       input logic [AW-1:0] a, input logic i, input logic rd,
                       input logic wr, input logic [DW-1:0] wd);
    rst_n = r; sel = s; bus_in = b; alt_in = a; inc = i;
    rd_req = rd; wr_req = wr; wr_data = wd;
  endtask

  initial begin
    int nb, na, nd, bad_ar;
    bit got;

    // Expected state of the RD_LAT=1 instance after each row's clock edge.
    tbl[0]  = '{1'b0, 2'b10, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 16'h00A0, 16'h00B0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b01, 16'h00A0, 16'h00B0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00B0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b10, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{1'b1, 2'b10, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5A5A, 16'h0020, 16'hBEEF, 16'h5A5A, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 16'hBEEF, 16'h5A5A, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 16'hBEEF, 16'h5A5A, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h0030, 16'hBEEF, 16'h1111, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 16'hBEEF, 16'h1111, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 16'hBEEF, 16'h1111, 1'b0, 0, 1'b0};

    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      drive(tbl[r].rst_n, tbl[r].sel, tbl[r].bus, tbl[r].alt, tbl[r].inc,
            tbl[r].rd, tbl[r].wr, tbl[r].wd);
      @(posedge clk);
      #1;
      if (r == 0) model_on = 1'b1;
      chk($sformatf("vec%0d.ar", r),    ar_a,        tbl[r].e_ar);
      chk($sformatf("vec%0d.dr", r),    dr_a,        tbl[r].e_dr);
      chk($sformatf("vec%0d.wdata", r), mem_wdata_a, tbl[r].e_wd);
      chk($sformatf("vec%0d.busy", r),  busy_a,      tbl[r].e_busy);
      chk($sformatf("vec%0d.done", r),  done_a,      tbl[r].e_done);
      chk($sformatf("vec%0d.wen", r),   mem_wen_a,   tbl[r].e_wen);
    end

    // Read latency on both instances; sel/inc during RD must not move AR.
    @(negedge clk);
    drive(1'b1, 2'b10, 16'h0040, '0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    na = 0; nb = 0; nd = 0; bad_ar = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      if (busy_b && ar_b !== 16'h0040) bad_ar++;
      if (done_b) begin
        nd++;
        chk("lat3.dr", dr_b, ram_f(16'h0040));
      end
      if (k == 0) drive(1'b1, 2'b10, 16'hABCD, '0, 1'b1, 1'b0, 1'b0, '0);
    end
    chk("lat1.busy_cycles", na, 1);
    chk("lat3.busy_cycles", nb, 3);
    chk("lat3.done_pulses", nd, 1);
    chk("lat3.ar_hold", bad_ar, 0);

    // Reset in the middle of a read.
    @(negedge clk);
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid.busy_a", busy_a, 1'b0);
    chk("rst_mid.busy_b", busy_b, 1'b0);
    chk("rst_mid.dr_a", dr_a, 16'h0000);
    chk("rst_mid.dr_b", dr_b, 16'h0000);
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_a || done_b) nd++;
    end
    chk("rst_mid.no_done", nd, 0);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (done_b) got = 1'b1;
    end
    chk("rst_mid.reread_done", got, 1'b1);
    chk("rst_mid.reread_dr", dr_b, ram_f(16'h0000));

    // Randomized traffic checked against the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      drive($urandom_range(0, 63) != 0,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0,
            16'($urandom));
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
